// File: rtl/bsg_manycore_ret_tracker.sv
// bsg_manycore_ret_tracker
// Tracks outstanding remote stores issued by the local processor, retires
// them on ACK return packets, and queues one ACK return packet per remote
// store delivered to the local processor. Also drives the fence status.
// Optional sticky error flag and checks: define BSG_MANYCORE_RET_TRACKER_ERR_EN.
module bsg_manycore_ret_tracker #(
  parameter int x_cord_width_p = 5,
  parameter int y_cord_width_p = 5,
  parameter int max_out_p      = 16,
  parameter int ack_els_p      = 4,
  localparam int ret_packet_width_lp = 5 + x_cord_width_p + y_cord_width_p,
  localparam int cnt_w_lp            = $clog2(max_out_p + 1)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           out_v_i,
  input  logic                           out_is_store_i,
  input  logic                           out_ready_i,
  output logic                           out_ready_o,
  output logic                           out_v_o,
  input  logic                           ret_v_i,
  input  logic [ret_packet_width_lp-1:0] ret_data_i,
  output logic                           ret_ready_o,
  input  logic                           in_v_i,
  input  logic                           in_yumi_i,
  input  logic                           in_is_store_i,
  input  logic [x_cord_width_p-1:0]      in_src_x_i,
  input  logic [y_cord_width_p-1:0]      in_src_y_i,
  output logic                           in_ready_o,
  output logic                           ack_v_o,
  output logic [ret_packet_width_lp-1:0] ack_data_o,
  input  logic                           ack_ready_i,
  input  logic                           fence_i,
  output logic                           fence_done_o,
  output logic [cnt_w_lp-1:0]            stores_pending_o,
  output logic                           err_o
);

  localparam int         ptr_w_lp  = (ack_els_p > 1) ? $clog2(ack_els_p) : 1;
  localparam logic [4:0] op_ack_lp = 5'h01;

  // Counter step: +1 on issue only, -1 on retire only, saturating at zero
  // so a stray ACK can never wrap the count.
  function automatic logic [cnt_w_lp-1:0] cnt_step(input logic [cnt_w_lp-1:0] c,
                                                   input logic inc,
                                                   input logic dec);
    if (inc && !dec)
      return c + cnt_w_lp'(1);
    if (dec && !inc && (c != '0))
      return c - cnt_w_lp'(1);
    return c;
  endfunction

  // FIFO pointer advance, wrapping modulo ack_els_p (not necessarily 2^n).
  function automatic logic [ptr_w_lp-1:0] ptr_step(input logic [ptr_w_lp-1:0] p);
    if (p == ptr_w_lp'(ack_els_p - 1))
      return '0;
    return p + ptr_w_lp'(1);
  endfunction

  logic [cnt_w_lp-1:0] cnt_r;
  logic                full_cnt;
  logic                gate_store;
  logic                issue;
  logic                retire;

  // Only the op field matters for retirement; coordinates are consumed.
  logic unused_ret_coords;
  assign unused_ret_coords = ^ret_data_i[x_cord_width_p+y_cord_width_p-1:0];

  assign full_cnt    = (cnt_r == cnt_w_lp'(max_out_p));
  assign gate_store  = out_is_store_i & full_cnt;
  assign out_v_o     = out_v_i & ~gate_store;
  assign out_ready_o = out_ready_i & ~gate_store;
  assign issue       = out_v_o & out_ready_i & out_is_store_i;
  assign retire      = ret_v_i & (ret_data_i[ret_packet_width_lp-1 -: 5] == op_ack_lp);

  assign ret_ready_o      = ~reset_i;
  assign stores_pending_o = cnt_r;
  assign fence_done_o     = ~reset_i & fence_i & (cnt_r == '0) & ~issue;

  // Outstanding remote store counter.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      cnt_r <= '0;
    else
      cnt_r <= cnt_step(cnt_r, issue, retire);
  end

  logic [ret_packet_width_lp-1:0] mem_r [ack_els_p];
  logic [ptr_w_lp-1:0]            wptr_r, rptr_r;
  logic                           full_r, empty_r;
  logic                           push_req, push, pop;
  logic [ptr_w_lp-1:0]            wptr_nxt, rptr_nxt;

  assign wptr_nxt   = ptr_step(wptr_r);
  assign rptr_nxt   = ptr_step(rptr_r);
  assign ack_v_o    = ~empty_r & ~reset_i;
  assign pop        = ack_v_o & ack_ready_i;
  // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
  assign in_ready_o = ~full_r | pop;
  assign push_req   = in_v_i & in_yumi_i & in_is_store_i;
  assign push       = push_req & in_ready_o;
  assign ack_data_o = mem_r[rptr_r];

  // Ack FIFO pointers and full/empty flags; the flags disambiguate wptr == rptr.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (push)
        wptr_r <= wptr_nxt;
      if (pop)
        rptr_r <= rptr_nxt;
      if (push && !pop) begin
        empty_r <= 1'b0;
        full_r  <= (wptr_nxt == rptr_r);
      end else if (pop && !push) begin
        full_r  <= 1'b0;
        empty_r <= (rptr_nxt == wptr_r);
      end
    end
  end

  // Ack FIFO storage: the ACK goes back to the source of the delivered store.
  always_ff @(posedge clk_i) begin
    if (push)
      mem_r[wptr_r] <= {op_ack_lp, in_src_y_i, in_src_x_i};
  end

`ifdef BSG_MANYCORE_RET_TRACKER_ERR_EN
  logic err_r;
  logic underflow;
  logic overflow;

  assign underflow = retire & ~issue & (cnt_r == '0);
  assign overflow  = push_req & ~in_ready_o;
  assign err_o     = err_r;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      err_r <= 1'b0;
    else if (underflow || overflow)
      err_r <= 1'b1;
  end

`ifndef SYNTHESIS
  // Simulation-time reporting of the same error conditions.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (underflow)
        $error("ret_tracker underflow");
      if (overflow)
        $error("ack overflow");
    end
  end
`endif
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: doc/bsg_manycore_ret_tracker.md
Name: bsg_manycore_ret_tracker

Overview:
- Sits between bsg_manycore_proc and the tile's two mesh routers (request and return).
- Counts outstanding remote stores issued by the local processor, and retires them on return packets from the return router.
- For every remote store delivered to the local processor, it queues one acknowledgement return packet towards the originating tile.
- Provides the fence status (stores_pending_o, fence_done_o) that the processor's "remote stores complete" operation reads.

Parameters:
- x_cord_width_p, 5, width of x coordinate.
- y_cord_width_p, 5, width of y coordinate.
- max_out_p, 16, maximum outstanding remote stores. Counter width is clog2(max_out_p+1).
- ack_els_p, 4, depth of the acknowledgement FIFO. Must be >= 2.
- ret_packet_width_lp, 5+x_cord_width_p+y_cord_width_p. Layout is {op[4:0], y_cord, x_cord}, x in the LSBs.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- out_v_i  in  1  proc request valid (towards request router)
- out_is_store_i  in  1  request is a remote store
- out_ready_i  in  1  request router ready
- out_ready_o  out  1  ready presented to proc (gated)
- out_v_o  out  1  valid presented to request router (gated)
- ret_v_i  in  1  return packet from return router, destined to this tile
- ret_data_i  in  ret_packet_width_lp  return packet
- ret_ready_o  out  1  always 1 after reset
- in_v_i  in  1  incoming request delivered to proc
- in_yumi_i  in  1  proc consumed the incoming request
- in_is_store_i  in  1  incoming request is a store
- in_src_x_i  in  x_cord_width_p  source x of incoming request
- in_src_y_i  in  y_cord_width_p  source y of incoming request
- in_ready_o  out  1  ack FIFO can accept; proc must not yumi a store while this is 0
- ack_v_o  out  1  ack packet valid to return router
- ack_data_o  out  ret_packet_width_lp  ack packet
- ack_ready_i  in  1  return router ready
- fence_i  in  1  processor fence request, level-sensitive
- fence_done_o  out  1  fence may retire
- stores_pending_o  out  counter width  current outstanding count
- err_o  out  1  sticky underflow error (only under the macro)

Behaviour:
- Reset:
  - Counter = 0. Ack FIFO empty.
  - ack_v_o = 0, fence_done_o = 0, err_o = 0.
  - ret_ready_o = 0 during reset, 1 thereafter.
- Issue handshake (combinational):
  - out_v_o = out_v_i & ~(out_is_store_i & full_cnt).
  - out_ready_o = out_ready_i & ~(out_is_store_i & full_cnt).
  - full_cnt is (counter == max_out_p).
  - An issue event is out_v_o & out_ready_i & out_is_store_i.
- Retire event: ret_v_i & (ret_data_i.op == 5'h01, ACK). Packets with other op values are consumed and ignored.
- Counter update, next cycle:
  - +1 on issue only.
  - −1 on retire only.
  - Unchanged when both or neither occur.
  - Retire at counter 0 (underflow): counter stays 0.
  - Issue can never occur at max because of the gating.
- stores_pending_o is registered and equals the counter.
- Fence: fence_done_o = fence_i & (counter == 0) & ~issue_this_cycle. Combinational, zero latency once the counter reaches 0.
- Ack generation:
  - On in_v_i & in_yumi_i & in_is_store_i, push {5'h01, in_src_y_i, in_src_x_i} into the FIFO.
  - in_ready_o = ~fifo_full, or 1 when a pop occurs in the same cycle (full-FIFO bypass: push and pop in one cycle are both allowed).
  - ack_v_o = ~fifo_empty. Pop on ack_v_o & ack_ready_i.
  - Head data is registered and stable while ack_v_o=1 and not popped.
  - Latency from push to ack_v_o is 1 cycle.
  - Non-store yumis push nothing.
- FIFO pointers wrap modulo ack_els_p; a full/empty bit disambiguates equal pointers.
- Reset mid-operation: all state cleared next edge. Acks still in the FIFO are dropped.

Optional Feature:
- Macro: BSG_MANYCORE_RET_TRACKER_ERR_EN.
- Defined:
  - err_o is set sticky on underflow or on a push while full without a pop; cleared only by reset.
  - Simulation prints $error with my coordinates unknown ("ret_tracker underflow"/"ack overflow").
- Undefined: err_o tied to 0 and no checks are generated.

Test Plan:
- Issue 3 stores, no returns -> stores_pending_o=3, fence_i=1 gives fence_done_o=0. Then 3 ACK returns -> count 0, fence_done_o=1 the next cycle.
- Issue 16 stores (max_out_p=16) with out_ready_i=1, then a 17th store -> out_v_o=0, out_ready_o=0. A non-store request at the same time passes. A return frees one slot and the 17th issues the following cycle.
- Same-cycle issue and ACK return at count 5 -> count stays 5. Non-ACK op return -> count unchanged.
- 4 incoming stores from (x=2,y=3) with ack_ready_i=0 -> in_ready_o=0 after the 4th, ack_data_o={5'h01,5'd3,5'd2}. Raise ack_ready_i -> 4 pops in 4 cycles.
- FIFO full while push and pop occur in the same cycle -> both accepted, occupancy stays 4, order preserved.
- With ERR_EN, retire at count 0 -> err_o=1 and held, count 0. Assert reset_i for 1 cycle mid-traffic -> all outputs return to reset values, err_o=0.
